// File: rtl/truth_table_pkg.sv
// Shared types and helpers for the truth-table sweep / term extraction blocks.
package truth_table_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_SETTLE,
      ST_SAMPLE,
      ST_EMIT,
      ST_DONE
   } state_t;

   // Number of truth-table rows for a function of n_vars inputs.
   function automatic int unsigned rows(input int unsigned n_vars);
      return 32'd1 << n_vars;
   endfunction

endpackage

// File: rtl/maxterm_extractor_term_scan.sv
// Combinational term detector: flags whether row idx is a term of the selected
// polarity and whether no further term exists above it.
module term_scan
   import truth_table_pkg::*;
#(
   parameter int unsigned N_VARS = 4
) (
   input  logic [rows(N_VARS)-1:0] table_i,
   input  logic [N_VARS-1:0]       idx_i,
   input  logic                    pol_i,
   output logic                    is_term_o,
   output logic                    last_term_o
);

   localparam int unsigned ROWS = rows(N_VARS);

   logic [ROWS-1:0] terms;
   logic [ROWS-1:0] above;

   // pol_i=0 selects zero rows (maxterms), pol_i=1 selects one rows (minterms).
   always_comb begin
      terms       = pol_i ? table_i : ~table_i;
      above       = (terms >> idx_i) >> 1;
      is_term_o   = terms[idx_i];
      last_term_o = (above == '0);
   end

endmodule

// File: rtl/maxterm_extractor.sv
// Sweeps an external function, captures its truth table and streams term indices.
// Optional MAXTERM_SOP_DUAL_EN adds sop_sel to emit minterms instead of maxterms.
module maxterm_extractor
   import truth_table_pkg::*;
#(
   parameter int unsigned N_VARS = 4,
   parameter int unsigned SETTLE = 1
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    start,
`ifdef MAXTERM_SOP_DUAL_EN
   input  logic                    sop_sel,
`endif
   output logic [N_VARS-1:0]       probe,
   input  logic                    f_in,
   output logic                    m_valid,
   input  logic                    m_ready,
   output logic [N_VARS-1:0]       m_index,
   output logic                    m_last,
   output logic                    busy,
   output logic                    done,
   output logic [N_VARS:0]         count,
   output logic [rows(N_VARS)-1:0] table_q
);

   localparam int unsigned ROWS = rows(N_VARS);
   localparam int unsigned CW   = N_VARS + 1;
   localparam int unsigned SW   = (SETTLE > 1) ? $clog2(SETTLE) : 1;
   localparam logic [N_VARS-1:0] LAST_IDX   = N_VARS'(ROWS - 1);
   localparam logic [SW-1:0]     SETTLE_END = SW'(SETTLE - 1);

   state_t              state_q;
   logic [N_VARS-1:0]   probe_q;
   logic [N_VARS-1:0]   idx_q;
   logic [SW-1:0]       settle_q;
   logic [CW-1:0]       count_q;
   logic [ROWS-1:0]     tbl_q;
   logic                busy_q;
   logic                done_q;
   logic                pol;
   logic                is_term;
   logic                last_term;

`ifdef MAXTERM_SOP_DUAL_EN
   logic pol_q;

   // Output polarity is fixed for the whole run once start is accepted.
   always_ff @(posedge clk) begin
      if (reset)
         pol_q <= 1'b0;
      else if (state_q == ST_IDLE && start)
         pol_q <= sop_sel;
   end

   assign pol = pol_q;
`else
   assign pol = 1'b0;
`endif

   term_scan #(
      .N_VARS (N_VARS)
   ) u_term_scan (
      .table_i     (tbl_q),
      .idx_i       (idx_q),
      .pol_i       (pol),
      .is_term_o   (is_term),
      .last_term_o (last_term)
   );

   // Sweep, sample and emit sequencer.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= ST_IDLE;
         probe_q  <= '0;
         idx_q    <= '0;
         settle_q <= '0;
         count_q  <= '0;
         tbl_q    <= '0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               if (start) begin
                  probe_q  <= '0;
                  idx_q    <= '0;
                  settle_q <= '0;
                  count_q  <= '0;
                  busy_q   <= 1'b1;
                  state_q  <= ST_SETTLE;
               end
            end
            ST_SETTLE: begin
               if (settle_q == SETTLE_END)
                  state_q <= ST_SAMPLE;
               else
                  settle_q <= settle_q + SW'(1);
            end
            ST_SAMPLE: begin
               tbl_q[probe_q] <= f_in;
               settle_q       <= '0;
               if (probe_q == LAST_IDX) begin
                  idx_q   <= '0;
                  state_q <= ST_EMIT;
               end else begin
                  probe_q <= probe_q + N_VARS'(1);
                  state_q <= ST_SETTLE;
               end
            end
            ST_EMIT: begin
               // Non-terms advance unconditionally; terms wait for the handshake.
               if (!is_term || m_ready) begin
                  if (is_term)
                     count_q <= count_q + CW'(1);
                  idx_q <= idx_q + N_VARS'(1);
                  if (idx_q == LAST_IDX) begin
                     done_q  <= 1'b1;
                     state_q <= ST_DONE;
                  end
               end
            end
            ST_DONE: begin
               probe_q <= '0;
               busy_q  <= 1'b0;
               state_q <= ST_IDLE;
            end
            default: begin
               busy_q  <= 1'b0;
               state_q <= ST_IDLE;
            end
         endcase
      end
   end

   assign m_valid = (state_q == ST_EMIT) && is_term;
   assign m_last  = m_valid && last_term;
   assign m_index = idx_q;
   assign probe   = probe_q;
   assign busy    = busy_q;
   assign done    = done_q;
   assign count   = count_q;
   assign table_q = tbl_q;

endmodule

// File: tb/tb_maxterm_extractor.sv
// Directed bench for maxterm_extractor; define MAXTERM_SOP_DUAL_EN to cover sop_sel.
module tb_maxterm_extractor;

   logic        clk = 1'b0;
   logic        reset;
   logic        start;
   logic [3:0]  probe;
   logic        f_in;
   logic        m_valid;
   logic        m_ready;
   logic [3:0]  m_index;
   logic        m_last;
   logic        busy;
   logic        done;
   logic [4:0]  count;
   logic [15:0] table_q;
`ifdef MAXTERM_SOP_DUAL_EN
   logic        sop_sel;
`endif

   int fmode;
   int n_cmp = 0;
   int n_err = 0;

   int got_idx[$];
   bit got_last[$];
   int done_cnt, done_cyc, stall_seen, valid_seen;
   bit timed_out;

   maxterm_extractor dut (
      .clk     (clk),
      .reset   (reset),
      .start   (start),
`ifdef MAXTERM_SOP_DUAL_EN
      .sop_sel (sop_sel),
`endif
      .probe   (probe),
      .f_in    (f_in),
      .m_valid (m_valid),
      .m_ready (m_ready),
      .m_index (m_index),
      .m_last  (m_last),
      .busy    (busy),
      .done    (done),
      .count   (count),
      .table_q (table_q)
   );

   always #5 clk = ~clk;

   // Function under test: 0 = PoS M(10,11,12,13), 1 = constant 1, other = constant 0.
   always_comb begin
      case (fmode)
         0:       f_in = !(probe >= 4'd10 && probe <= 4'd13);
         1:       f_in = 1'b1;
         default: f_in = 1'b0;
      endcase
   end

   task automatic run_collect(input int stall_idx, input int stall_n, input bit poke_start);
      int cyc;
      int stall_left;
      int post;
      bit seen_done;
      got_idx.delete();
      got_last.delete();
      done_cnt = 0; done_cyc = 0; stall_seen = 0; valid_seen = 0; timed_out = 0;
      stall_left = stall_n; post = 0; seen_done = 0;
      @(negedge clk); start = 1'b1; m_ready = 1'b1;
      @(negedge clk); start = 1'b0; cyc = 1;
      while (1) begin
         if (done) begin
            done_cnt++;
            if (!seen_done) done_cyc = cyc;
            seen_done = 1'b1;
         end
         if (m_valid) valid_seen++;
         m_ready = 1'b1;
         if (m_valid) begin
            if (stall_left > 0 && int'(m_index) == stall_idx) begin
               m_ready = 1'b0;
               stall_left--;
               stall_seen++;
            end else begin
               got_idx.push_back(int'(m_index));
               got_last.push_back(m_last);
            end
         end
         start = poke_start && (cyc == 10 || cyc == 40 || cyc == 45);
         if (seen_done) post++;
         if (post > 4) break;
         if (cyc > 2000) begin
            timed_out = 1'b1;
            break;
         end
         @(negedge clk);
         cyc++;
      end
      start = 1'b0;
      m_ready = 1'b1;
   endtask

   task automatic test_reset();
      reset = 1'b1; start = 1'b0; m_ready = 1'b0; fmode = 0;
      repeat (3) @(negedge clk);
      n_cmp++;
      if ({probe, m_index, count, table_q} !== 29'd0) begin
         n_err++;
         $display("FAIL reset_regs: got %h expected 0", {probe, m_index, count, table_q});
      end
      n_cmp++;
      if ({m_valid, m_last, busy, done} !== 4'b0000) begin
         n_err++;
         $display("FAIL reset_flags: got %b expected 0000", {m_valid, m_last, busy, done});
      end
      reset = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_pos_basic();
      int exp[$];
      exp = '{10, 11, 12, 13};
      fmode = 0;
      run_collect(-1, 0, 1'b0);
      n_cmp++;
      if (timed_out) begin n_err++; $display("FAIL pos_timeout: got timeout expected done"); end
      n_cmp++;
      if (got_idx.size() !== exp.size()) begin
         n_err++; $display("FAIL pos_len: got %0d expected %0d", got_idx.size(), exp.size());
      end else begin
         foreach (exp[i]) begin
            n_cmp++;
            if (got_idx[i] !== exp[i]) begin
               n_err++; $display("FAIL pos_idx[%0d]: got %0d expected %0d", i, got_idx[i], exp[i]);
            end
            n_cmp++;
            if (got_last[i] !== (i == 3)) begin
               n_err++; $display("FAIL pos_last[%0d]: got %0d expected %0d", i, got_last[i], (i == 3));
            end
         end
      end
      n_cmp++;
      if (count !== 5'd4) begin n_err++; $display("FAIL pos_count: got %0d expected 4", count); end
      n_cmp++;
      if (table_q !== 16'hC3FF) begin n_err++; $display("FAIL pos_table: got %h expected c3ff", table_q); end
      n_cmp++;
      if (done_cnt !== 1) begin n_err++; $display("FAIL pos_done_cnt: got %0d expected 1", done_cnt); end
      n_cmp++;
      if (busy !== 1'b0 || probe !== 4'd0) begin
         n_err++; $display("FAIL pos_idle: got busy=%b probe=%0d expected busy=0 probe=0", busy, probe);
      end
   endtask

   task automatic test_const_one();
      fmode = 1;
      run_collect(-1, 0, 1'b0);
      n_cmp++;
      if (valid_seen !== 0) begin n_err++; $display("FAIL one_valid: got %0d cycles expected 0", valid_seen); end
      n_cmp++;
      if (count !== 5'd0) begin n_err++; $display("FAIL one_count: got %0d expected 0", count); end
      n_cmp++;
      if (table_q !== 16'hFFFF) begin n_err++; $display("FAIL one_table: got %h expected ffff", table_q); end
      n_cmp++;
      if (done_cyc !== 49) begin n_err++; $display("FAIL one_done_cycle: got %0d expected 49", done_cyc); end
      n_cmp++;
      if (done_cnt !== 1) begin n_err++; $display("FAIL one_done_cnt: got %0d expected 1", done_cnt); end
   endtask

   task automatic test_const_zero();
      fmode = 2;
      run_collect(-1, 0, 1'b0);
      n_cmp++;
      if (got_idx.size() !== 16) begin
         n_err++; $display("FAIL zero_len: got %0d expected 16", got_idx.size());
      end else begin
         for (int i = 0; i < 16; i++) begin
            n_cmp++;
            if (got_idx[i] !== i || got_last[i] !== (i == 15)) begin
               n_err++;
               $display("FAIL zero_term[%0d]: got idx=%0d last=%0d expected idx=%0d last=%0d",
                        i, got_idx[i], got_last[i], i, (i == 15));
            end
         end
      end
      n_cmp++;
      if (count !== 5'b10000) begin n_err++; $display("FAIL zero_count: got %b expected 10000", count); end
      n_cmp++;
      if (table_q !== 16'h0000) begin n_err++; $display("FAIL zero_table: got %h expected 0000", table_q); end
   endtask

   task automatic test_backpressure();
      int exp[$];
      exp = '{10, 11, 12, 13};
      fmode = 0;
      run_collect(11, 3, 1'b0);
      n_cmp++;
      if (stall_seen !== 3) begin n_err++; $display("FAIL bp_hold: got %0d held cycles expected 3", stall_seen); end
      n_cmp++;
      if (got_idx !== exp) begin
         n_err++; $display("FAIL bp_seq: got %p expected %p", got_idx, exp);
      end
      n_cmp++;
      if (count !== 5'd4) begin n_err++; $display("FAIL bp_count: got %0d expected 4", count); end
   endtask

   task automatic test_reset_mid();
      int exp[$];
      int dn;
      exp = '{10, 11, 12, 13};
      fmode = 0;
      @(negedge clk); start = 1'b1;
      @(negedge clk); start = 1'b0;
      for (int k = 0; k < 100 && probe !== 4'd7; k++) @(negedge clk);
      n_cmp++;
      if (probe !== 4'd7) begin n_err++; $display("FAIL mid_reach7: got probe=%0d expected 7", probe); end
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      n_cmp++;
      if ({probe, m_index, count, table_q} !== 29'd0 || {m_valid, m_last, busy, done} !== 4'b0) begin
         n_err++;
         $display("FAIL mid_reset_vals: got regs=%h flags=%b expected 0/0000",
                  {probe, m_index, count, table_q}, {m_valid, m_last, busy, done});
      end
      dn = 0;
      repeat (60) begin
         @(negedge clk);
         if (done || busy) dn++;
      end
      n_cmp++;
      if (dn !== 0) begin n_err++; $display("FAIL mid_no_done: got %0d active cycles expected 0", dn); end
      run_collect(-1, 0, 1'b0);
      n_cmp++;
      if (got_idx !== exp || count !== 5'd4 || table_q !== 16'hC3FF) begin
         n_err++;
         $display("FAIL mid_rerun: got %p count=%0d table=%h expected %p count=4 table=c3ff",
                  got_idx, count, table_q, exp);
      end
   endtask

   task automatic test_start_busy();
      int exp[$];
      exp = '{10, 11, 12, 13};
      fmode = 0;
      run_collect(-1, 0, 1'b1);
      n_cmp++;
      if (got_idx !== exp) begin n_err++; $display("FAIL busy_seq: got %p expected %p", got_idx, exp); end
      n_cmp++;
      if (count !== 5'd4) begin n_err++; $display("FAIL busy_count: got %0d expected 4", count); end
      n_cmp++;
      if (done_cnt !== 1) begin n_err++; $display("FAIL busy_done_cnt: got %0d expected 1", done_cnt); end
   endtask

`ifdef MAXTERM_SOP_DUAL_EN
   task automatic test_sop();
      int exp[$];
      exp = '{0, 1, 2, 3, 4, 5, 6, 7, 8, 9, 14, 15};
      fmode = 0;
      sop_sel = 1'b1;
      run_collect(-1, 0, 1'b0);
      sop_sel = 1'b0;
      n_cmp++;
      if (got_idx !== exp) begin n_err++; $display("FAIL sop_seq: got %p expected %p", got_idx, exp); end
      n_cmp++;
      if (count !== 5'd12) begin n_err++; $display("FAIL sop_count: got %0d expected 12", count); end
      n_cmp++;
      if (got_last.size() != 12 || got_last[11] !== 1'b1 || got_last[9] !== 1'b0) begin
         n_err++; $display("FAIL sop_last: got %p expected last only on 15", got_last);
      end
   endtask
`endif

   initial begin
      reset = 1'b1; start = 1'b0; m_ready = 1'b0; fmode = 0;
`ifdef MAXTERM_SOP_DUAL_EN
      sop_sel = 1'b0;
`endif
      test_reset();
      test_pos_basic();
      test_const_one();
      test_const_zero();
      test_backpressure();
      test_reset_mid();
      test_start_busy();
`ifdef MAXTERM_SOP_DUAL_EN
      test_sop();
`endif
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: got no completion expected finish");
      $fatal(1, "watchdog expired");
   end

endmodule
